// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding for pipeline stage registers
//
// Purpose: state constants and helpers reused by every pipeline stage instance
// (ID/EX, EX/MEM, MEM/WB) built on pipe_stage_reg.
package pipe_pkg;

    // Number of held entries doubles as the encoding, so occupancy is a direct decode.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

    // Held-entry count for a state; the unused encoding reads as empty.
    function automatic logic [1:0] state_occupancy(input pipe_state_e s);
        logic [1:0] occ;
        case (s)
            ST_ONE:  occ = 2'd1;
            ST_FULL: occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - two-entry skid-buffered pipeline stage register
//
// Purpose: valid/ready pipeline register with a main entry (drives out_data)
// and a skid entry, so in_ready depends only on registered state and the
// stage still sustains one transfer per cycle.
//
// Ports:
//   clk        - clock, rising edge
//   reset_n    - asynchronous active-low reset
//   flush      - discard all held entries (overrides everything else)
//   in_valid   - upstream payload valid
//   in_ready   - stage can accept a payload (low only when FULL)
//   in_data    - upstream payload, WIDTH bits
//   out_valid  - downstream payload valid
//   out_ready  - downstream accepts payload
//   out_data   - downstream payload (main register)
//   occupancy  - held entries, 0..2
//   stall_cnt  - saturating count of cycles with out_valid & !out_ready
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_DATA = '0,
    parameter int               CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    pipe_state_e      state_q,     state_d;
    logic [WIDTH-1:0] main_q,      main_d;
    logic [WIDTH-1:0] skid_q,      skid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic in_fire;
    logic out_fire;

    // Handshake outputs decode the state register only; no path from out_ready.
    assign in_ready  = (state_q == ST_EMPTY) || (state_q == ST_ONE);
    assign out_valid = (state_q == ST_ONE)   || (state_q == ST_FULL);
    assign out_data  = main_q;
    assign occupancy = state_occupancy(state_q);
    assign stall_cnt = stall_cnt_q;

    assign in_fire  = in_valid  & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        stall_cnt_d = stall_cnt_q;

        if (flush) begin
            // Drop entries by state only; data registers keep their contents.
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = ST_FULL;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so in_valid cannot fire.
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        // Back-pressure counter saturates and survives flush.
        if (out_valid && !out_ready && !flush && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_EMPTY;
            main_q      <= RESET_DATA;
            skid_q      <= RESET_DATA;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic        in_ready_a,  out_valid_a;
    logic [7:0]  out_data_a;
    logic [1:0]  occupancy_a;
    logic [15:0] stall_cnt_a;

    logic        in_ready_s,  out_valid_s;
    logic [7:0]  out_data_s;
    logic [1:0]  occupancy_s;
    logic [1:0]  stall_cnt_s;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO of at most two payloads plus two back-pressure counters.
    logic [7:0] mq[$];
    int         m_cnt_a;
    int         m_cnt_s;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(8), .RESET_DATA(8'h5A), .CNT_W(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
        .occupancy(occupancy_a), .stall_cnt(stall_cnt_a)
    );

    pipe_stage_reg #(.WIDTH(8), .RESET_DATA(8'hA5), .CNT_W(2)) dut_s (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .occupancy(occupancy_s), .stall_cnt(stall_cnt_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_cnt_a = 0;
        m_cnt_s = 0;
    endtask

    // Apply one rising edge's worth of rules to the model using current inputs.
    task automatic model_edge();
        bit ov, ofire, ifire;
        ov = (mq.size() > 0);
        if (ov && !out_ready && !flush) begin
            if (m_cnt_a < 65535) m_cnt_a++;
            if (m_cnt_s < 3)     m_cnt_s++;
        end
        if (flush) begin
            mq.delete();
        end else begin
            ofire = ov && out_ready;
            ifire = in_valid && (mq.size() < 2);
            if (ofire) void'(mq.pop_front());
            if (ifire) mq.push_back(in_data);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] occ;
        occ = mq.size();
        chk({tag, ".in_ready_a"},  in_ready_a,  mq.size() < 2);
        chk({tag, ".out_valid_a"}, out_valid_a, mq.size() > 0);
        chk({tag, ".occ_a"},       occupancy_a, occ);
        chk({tag, ".stall_a"},     stall_cnt_a, m_cnt_a);
        chk({tag, ".in_ready_s"},  in_ready_s,  mq.size() < 2);
        chk({tag, ".out_valid_s"}, out_valid_s, mq.size() > 0);
        chk({tag, ".occ_s"},       occupancy_s, occ);
        chk({tag, ".stall_s"},     stall_cnt_s, m_cnt_s);
        if (mq.size() > 0) begin
            chk({tag, ".data_a"}, out_data_a, mq[0]);
            chk({tag, ".data_s"}, out_data_s, mq[0]);
        end
    endtask

    // Drive inputs at the falling edge, clock once, then compare at the next falling edge.
    task automatic step(input string tag, input logic iv, input logic [7:0] id,
                        input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        model_reset();

        do_reset("reset");

        // Single payload latency.
        step("first", 1'b1, 8'h11, 1'b1, 1'b0);
        chk("first.valid_const", out_valid_a, 1'b1);
        chk("first.data_const",  out_data_a,  8'h11);
        chk("first.occ_const",   occupancy_a, 2'd1);
        step("drain1", 1'b0, 8'h00, 1'b1, 1'b0);

        // Back-to-back stream: in_ready stays high and data follows in order.
        for (int i = 1; i <= 8; i++) begin
            chk("stream.in_ready", in_ready_a, 1'b1);
            step("stream", 1'b1, 8'(i), 1'b1, 1'b0);
            chk("stream.data_const", out_data_a, i);
        end
        step("stream_tail", 1'b0, 8'h00, 1'b1, 1'b0);

        // Fill to FULL, third push ignored, then drain in order.
        step("fill_a", 1'b1, 8'h0A, 1'b0, 1'b0);
        step("fill_b", 1'b1, 8'h0B, 1'b0, 1'b0);
        chk("full.occ_const",   occupancy_a, 2'd2);
        chk("full.ready_const", in_ready_a,  1'b0);
        step("ignore_c", 1'b1, 8'h0C, 1'b0, 1'b0);
        chk("full.head_const", out_data_a, 8'h0A);
        step("drain_a", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain.b_const", out_data_a, 8'h0B);
        step("drain_b", 1'b0, 8'h00, 1'b1, 1'b0);

        // Flush while FULL with a simultaneous push.
        step("fill2_a", 1'b1, 8'h0A, 1'b0, 1'b0);
        step("fill2_b", 1'b1, 8'h0B, 1'b0, 1'b0);
        step("flush", 1'b1, 8'h0C, 1'b0, 1'b1);
        chk("flush.occ_const",   occupancy_a, 2'd0);
        chk("flush.valid_const", out_valid_a, 1'b0);
        chk("flush.ready_const", in_ready_a,  1'b1);
        step("post_flush", 1'b0, 8'h00, 1'b1, 1'b0);

        // Saturating stall counter on the narrow instance.
        do_reset("reset2");
        step("stall_load", 1'b1, 8'h33, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            step("stall", 1'b0, 8'h00, 1'b0, 1'b0);
            chk("stall.narrow_const", stall_cnt_s, (i < 3) ? i : 3);
        end
        step("stall_flush", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("stall.after_flush_const", stall_cnt_s, 2'd3);

        // Asynchronous reset mid-cycle while FULL.
        step("ar_a", 1'b1, 8'h0A, 1'b0, 1'b0);
        step("ar_b", 1'b1, 8'h0B, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        step("after_reset", 1'b1, 8'h77, 1'b1, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 1'($urandom_range(0, 3) != 0),
                 8'($urandom),
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 31) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
